// File: rtl/fp_mul_stream.sv
// Streaming valid/ready wrapper around a fixed-latency fp_mul core: credit-gated
// input, valid/tag pipe matching the core latency, and a FWFT result FIFO.
module fp_mul_stream #(
    parameter int unsigned MUL_LATENCY = 5,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TAG_W       = 4
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_en,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [31:0]      mul_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_q,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]             rst_sync;
    logic                   rst_n;
    logic [MUL_LATENCY-1:0] vld;
    logic [TAG_W-1:0]       tag_pipe [MUL_LATENCY];
    logic [31:0]            q_mem    [DEPTH];
    logic [TAG_W-1:0]       t_mem    [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [CW-1:0]          credits;
    logic                   accept;
    logic                   pop;
    logic                   wr;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) rst_sync <= '0;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign mul_en    = areset_n;
    assign mul_a     = in_a;
    assign mul_b     = in_b;
    assign in_ready  = rst_n && (credits < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign wr        = vld[MUL_LATENCY-1];
    assign busy      = (credits != '0);
    assign out_q     = out_valid ? q_mem[rd_ptr] : '0;
    assign out_tag   = out_valid ? t_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int unsigned i = 0; i < MUL_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            vld[0]      <= accept;
            tag_pipe[0] <= in_tag;
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                vld[i]      <= vld[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Credits span in-flight plus buffered results, so the FIFO cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(wr && count == DEPTH_C && !pop));
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            q_mem[wr_ptr] <= mul_q;
            t_mem[wr_ptr] <= tag_pipe[MUL_LATENCY-1];
        end
    end
endmodule
